// File: rtl/hazard_flow_ctrl.sv
// Pipeline control-flow and RAW hazard sequencer for the 16-bit core.
// Optional stall/flush event counters are enabled by defining HAZ_CNT_EN.
module hazard_flow_ctrl #(
   parameter int unsigned IW    = 16,
   parameter int unsigned RA    = 4,
   parameter int unsigned DEPTH = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] inst_in,
   input  logic [2:0]    flag,
   output logic [IW-1:0] inst_out,
   output logic          issue_valid,
   output logic          stall,
   output logic          flush,
   output logic          pc_hold,
   output logic [1:0]    pc_sel,
   output logic          ret_load,
   output logic          ret_restore
`ifdef HAZ_CNT_EN
   ,
   output logic [15:0]   stall_cnt,
   output logic [15:0]   flush_cnt
`endif
);

   localparam logic [3:0] OpSll  = 4'h4;
   localparam logic [3:0] OpSrl  = 4'h5;
   localparam logic [3:0] OpSra  = 4'h6;
   localparam logic [3:0] OpRl   = 4'h7;
   localparam logic [3:0] OpLw   = 4'h8;
   localparam logic [3:0] OpSw   = 4'h9;
   localparam logic [3:0] OpLhb  = 4'hA;
   localparam logic [3:0] OpLlb  = 4'hB;
   localparam logic [3:0] OpB    = 4'hC;
   localparam logic [3:0] OpJal  = 4'hD;
   localparam logic [3:0] OpJr   = 4'hE;
   localparam logic [3:0] OpExec = 4'hF;

   typedef enum logic [1:0] {StRun, StRedir, StExec1, StExec2} state_e;

   state_e state_q, state_d;

   // History keeps only what the hazard/control logic needs: writer flag, rd, and
   // the opcode of the newest entry.
   logic          hist_wr_q [DEPTH];
   logic [RA-1:0] hist_rd_q [DEPTH];
   logic [3:0]    h0_op_q;
   logic          h0_vld_q;

   function automatic logic writes_reg(input logic [3:0] op, input logic [RA-1:0] rd);
      logic wr_op;
      wr_op = (op <= OpLw) || (op == OpLhb) || (op == OpLlb) || (op == OpJal);
      return wr_op && ((rd != '1) || (op == OpJal));
   endfunction

   logic [3:0]    id_op;
   logic [RA-1:0] id_rd, id_rs, id_rt;
   logic          rd_rs, rd_rt, rd_rd;
   logic          raw;

   assign id_op = inst_in[IW-1 -: 4];
   assign id_rd = inst_in[IW-5 -: RA];
   assign id_rs = inst_in[IW-9 -: RA];
   assign id_rt = inst_in[IW-13 -: RA];

   always_comb begin
      rd_rs = (id_op <= OpSw) || (id_op == OpJr);
      rd_rt = (id_op < OpSll);
      rd_rd = (id_op == OpSw) || (id_op == OpLhb);
      raw   = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (hist_wr_q[k] && ((rd_rs && (hist_rd_q[k] == id_rs)) ||
                              (rd_rt && (hist_rd_q[k] == id_rt)) ||
                              (rd_rd && (hist_rd_q[k] == id_rd)))) begin
            raw = 1'b1;
         end
      end
   end

   // Branch condition of the B now in EX, using the EX-stage flags {Z,V,N}.
   logic [3:0] br_cond;
   logic       br_true;
   logic       ctl_branch, ctl_jump, ctl_exec;

   assign br_cond = 4'(hist_rd_q[0]);

   always_comb begin
      case (br_cond)
         4'd0:    br_true = flag[2];
         4'd1:    br_true = !flag[2];
         4'd2:    br_true = !flag[2] && !flag[0];
         4'd3:    br_true = flag[0];
         4'd4:    br_true = flag[2] || !flag[0];
         4'd5:    br_true = flag[0] || flag[2];
         4'd6:    br_true = flag[1];
         4'd7:    br_true = 1'b1;
         default: br_true = 1'b0;
      endcase
   end

   assign ctl_branch = h0_vld_q && (h0_op_q == OpB) && br_true;
   assign ctl_jump   = h0_vld_q && ((h0_op_q == OpJal) || (h0_op_q == OpJr));
   assign ctl_exec   = h0_vld_q && (h0_op_q == OpExec);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (ctl_branch)    state_d = StRun;
            else if (ctl_jump) state_d = StRedir;
            else if (ctl_exec) state_d = StExec1;
            else               state_d = StRun;
         end
         StRedir: state_d = StRun;
         StExec1: state_d = raw ? StExec1 : StExec2;
         StExec2: state_d = StRun;
      endcase
   end

   // Output logic; outputs sit at their reset values while rst is high.
   always_comb begin
      inst_out    = '0;
      issue_valid = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      pc_hold     = 1'b0;
      pc_sel      = 2'b00;
      ret_load    = 1'b0;
      ret_restore = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StRun: begin
               if (ctl_branch) begin
                  flush  = 1'b1;
                  pc_sel = 2'b01;
               end else if (ctl_jump) begin
                  flush  = 1'b1;
                  pc_sel = 2'b10;
               end else if (ctl_exec) begin
                  flush    = 1'b1;
                  pc_sel   = 2'b11;
                  ret_load = 1'b1;
               end else if (raw) begin
                  stall   = 1'b1;
                  pc_hold = 1'b1;
               end else begin
                  inst_out    = inst_in;
                  issue_valid = 1'b1;
               end
            end
            StRedir: flush = 1'b1;
            StExec1: begin
               pc_hold = 1'b1;
               if (raw) begin
                  stall = 1'b1;
               end else if (inst_in[IW-1 -: 2] == 2'b11) begin
                  flush = 1'b1;
               end else begin
                  inst_out    = inst_in;
                  issue_valid = 1'b1;
               end
            end
            StExec2: ret_restore = 1'b1;
         endcase
      end
   end

   logic [3:0]    iss_op;
   logic [RA-1:0] iss_rd;

   assign iss_op = inst_out[IW-1 -: 4];
   assign iss_rd = inst_out[IW-5 -: RA];

   always_ff @(posedge clk) begin
      if (rst) begin
         h0_vld_q <= 1'b0;
         h0_op_q  <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            hist_wr_q[k] <= 1'b0;
            hist_rd_q[k] <= '0;
         end
      end else begin
         h0_vld_q     <= issue_valid;
         h0_op_q      <= iss_op;
         hist_wr_q[0] <= issue_valid && writes_reg(iss_op, iss_rd);
         hist_rd_q[0] <= iss_rd;
         for (int k = 1; k < DEPTH; k++) begin
            hist_wr_q[k] <= hist_wr_q[k-1];
            hist_rd_q[k] <= hist_rd_q[k-1];
         end
      end
   end

`ifdef HAZ_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
         if (flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_flow_ctrl.sv
// Bench for hazard_flow_ctrl: directed scenarios plus random instruction streams
// checked cycle by cycle against a behavioural pipeline model.
module tb_hazard_flow_ctrl;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] inst_in;
   logic [2:0]  flag;
   logic [15:0] inst_out;
   logic        issue_valid, stall, flush, pc_hold, ret_load, ret_restore;
   logic [1:0]  pc_sel;
`ifdef HAZ_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   hazard_flow_ctrl #(.IW(16), .RA(4), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_in     (inst_in),
      .flag        (flag),
      .inst_out    (inst_out),
      .issue_valid (issue_valid),
      .stall       (stall),
      .flush       (flush),
      .pc_hold     (pc_hold),
      .pc_sel      (pc_sel),
      .ret_load    (ret_load),
`ifdef HAZ_CNT_EN
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
`endif
      .ret_restore (ret_restore)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        v;
      logic [15:0] i;
   } ent_t;

   ent_t m_hist[$];
   int   m_phase;     // 0 normal, 1 redirect bubble, 2 EXEC target, 3 EXEC return
   int   m_next;
   int   m_stall_cnt, m_flush_cnt;

   logic [15:0] e_inst;
   logic        e_iv, e_stall, e_flush, e_hold, e_rload, e_rrest;
   logic [1:0]  e_sel;

   function automatic bit m_reads(input logic [15:0] i, input int r);
      int op = int'(i[15:12]);
      int rd = int'(i[11:8]);
      int rs = int'(i[7:4]);
      int rt = int'(i[3:0]);
      if (op <= 3)             return (r == rs) || (r == rt);
      if (op >= 4 && op <= 8)  return r == rs;
      if (op == 9)             return (r == rs) || (r == rd);
      if (op == 10)            return r == rd;
      if (op == 14)            return r == rs;
      return 1'b0;
   endfunction

   function automatic bit m_writes(input ent_t e, input int r);
      int op = int'(e.i[15:12]);
      if (!e.v || int'(e.i[11:8]) != r) return 1'b0;
      if (op == 13) return 1'b1;
      return (op <= 8 || op == 10 || op == 11) && r != 15;
   endfunction

   function automatic bit m_taken(input logic [3:0] c, input logic [2:0] f);
      bit z = f[2], v = f[1], n = f[0];
      bit tbl [8] = '{z, !z, !z && !n, n, z || !n, n || z, v, 1'b1};
      return (c < 8) ? tbl[c] : 1'b0;
   endfunction

   function automatic bit m_hazard(input logic [15:0] i);
      for (int k = 0; k < DEPTH; k++)
         for (int r = 0; r < 16; r++)
            if (m_reads(i, r) && m_writes(m_hist[k], r)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_eval();
      ent_t h;
      int   op;
      e_inst = '0; e_iv = 0; e_stall = 0; e_flush = 0; e_hold = 0;
      e_sel = 2'b00; e_rload = 0; e_rrest = 0; m_next = 0;
      h  = m_hist[0];
      op = int'(h.i[15:12]);
      if (!rst) begin
         case (m_phase)
            0: begin
               if (h.v && op == 12 && m_taken(h.i[11:8], flag)) begin
                  e_flush = 1; e_sel = 2'b01;
               end else if (h.v && (op == 13 || op == 14)) begin
                  e_flush = 1; e_sel = 2'b10; m_next = 1;
               end else if (h.v && op == 15) begin
                  e_flush = 1; e_sel = 2'b11; e_rload = 1; m_next = 2;
               end else if (m_hazard(inst_in)) begin
                  e_stall = 1; e_hold = 1;
               end else begin
                  e_inst = inst_in; e_iv = 1;
               end
            end
            1: e_flush = 1;
            2: begin
               e_hold = 1;
               if (m_hazard(inst_in)) begin
                  e_stall = 1; m_next = 2;
               end else begin
                  m_next = 3;
                  if (inst_in[15:14] == 2'b11) e_flush = 1;
                  else begin e_inst = inst_in; e_iv = 1; end
               end
            end
            default: e_rrest = 1;
         endcase
      end
   endtask

   task automatic m_advance();
      if (rst) begin
         m_hist.delete();
         for (int k = 0; k < DEPTH; k++) m_hist.push_back('0);
         m_phase = 0;
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         m_hist.push_front({e_iv, e_inst});
         void'(m_hist.pop_back());
         m_phase = m_next;
         if (e_stall && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
         if (e_flush && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
      end
   endtask

   // One clock: advance the model past the edge, apply new inputs, compare.
   task automatic cyc(input logic r, input logic [15:0] i, input logic [2:0] f);
      @(posedge clk);
      m_advance();
      #1;
      rst = r; inst_in = i; flag = f;
      #1;
      m_eval();
      check_eq("inst_out", 32'(inst_out), 32'(e_inst));
      check_eq("issue_valid", 32'(issue_valid), 32'(e_iv));
      check_eq("stall", 32'(stall), 32'(e_stall));
      check_eq("flush", 32'(flush), 32'(e_flush));
      check_eq("pc_hold", 32'(pc_hold), 32'(e_hold));
      check_eq("pc_sel", 32'(pc_sel), 32'(e_sel));
      check_eq("ret_load", 32'(ret_load), 32'(e_rload));
      check_eq("ret_restore", 32'(ret_restore), 32'(e_rrest));
`ifdef HAZ_CNT_EN
      check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
      check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
`endif
   endtask

   function automatic logic [15:0] rand_inst();
      logic [3:0] op = 4'($urandom_range(0, 15));
      logic [3:0] regs [4] = '{4'd0, 4'd1, 4'd2, 4'd15};
      logic [3:0] a = regs[$urandom_range(0, 3)];
      logic [3:0] b = regs[$urandom_range(0, 3)];
      logic [3:0] c = regs[$urandom_range(0, 3)];
      if (op == 4'hC) a = 4'($urandom_range(0, 15));
      if (op == 4'hD) a = 4'hF;
      return {op, a, b, c};
   endfunction

   initial begin
      rst = 1'b1; inst_in = '0; flag = '0;
      m_phase = 0; m_next = 0;

      // Reset values
      cyc(1, 16'h0123, 3'b111);
      cyc(1, 16'h0123, 3'b111);
      check_eq("rst_issue", 32'(issue_valid), 32'd0);
      check_eq("rst_inst", 32'(inst_out), 32'd0);

      // RAW on R1 with DEPTH 3: three stall cycles, then issue
      cyc(0, 16'h0123, 3'b000);
      check_eq("add_issue", 32'(inst_out), 32'h0123);
      for (int n = 0; n < 3; n++) begin
         cyc(0, 16'h0411, 3'b000);
         check_eq("raw_stall", 32'(stall), 32'd1);
      end
      cyc(0, 16'h0411, 3'b000);
      check_eq("raw_release", 32'(inst_out), 32'h0411);

      // BEQ taken with Z=1, then not taken with Z=0
      cyc(0, 16'h1123, 3'b000);
      cyc(0, 16'hC005, 3'b100);
      cyc(0, 16'h0000, 3'b100);
      check_eq("beq_flush", 32'(flush), 32'd1);
      check_eq("beq_sel", 32'(pc_sel), 32'd1);
      cyc(0, 16'hC005, 3'b000);
      cyc(0, 16'h0000, 3'b000);
      check_eq("beq_nt_flush", 32'(flush), 32'd0);
      check_eq("beq_nt_issue", 32'(issue_valid), 32'd1);

      // JAL: squash, redirect bubble, then JR R15 stalls on the link write
      cyc(0, 16'hDF00, 3'b000);
      cyc(0, 16'h0123, 3'b000);
      check_eq("jal_sel", 32'(pc_sel), 32'd2);
      cyc(0, 16'h0123, 3'b000);
      check_eq("redir_flush", 32'(flush), 32'd1);
      cyc(0, 16'hE0F0, 3'b000);
      check_eq("jr_link_stall", 32'(stall), 32'd1);
      cyc(0, 16'hE0F0, 3'b000);
      cyc(0, 16'h0000, 3'b000);
      cyc(0, 16'h0000, 3'b000);

      // ADD R15 is not a link write: reader of R15 issues at once
      cyc(0, 16'h0F12, 3'b000);
      cyc(0, 16'h90F0, 3'b000);
      check_eq("r15_nostall", 32'(stall), 32'd0);

      // EXEC with an ADD at the target
      cyc(0, 16'hF000, 3'b000);
      cyc(0, 16'h0000, 3'b000);
      check_eq("exec_rload", 32'(ret_load), 32'd1);
      cyc(0, 16'h0567, 3'b000);
      check_eq("exec1_issue", 32'(inst_out), 32'h0567);
      check_eq("exec1_hold", 32'(pc_hold), 32'd1);
      cyc(0, 16'h0567, 3'b000);
      check_eq("exec2_restore", 32'(ret_restore), 32'd1);

      // EXEC whose target is a branch: squashed
      cyc(0, 16'hF000, 3'b000);
      cyc(0, 16'h0000, 3'b000);
      cyc(0, 16'hC700, 3'b000);
      check_eq("exec1_squash", 32'(flush), 32'd1);
      check_eq("exec1_sq_iv", 32'(issue_valid), 32'd0);
      cyc(0, 16'h0000, 3'b000);

      // Reset while in EXEC1
      cyc(0, 16'hF000, 3'b000);
      cyc(0, 16'h0000, 3'b000);
      cyc(1, 16'h0567, 3'b000);
      check_eq("rst_exec_hold", 32'(pc_hold), 32'd0);
      cyc(0, 16'h0567, 3'b000);
      check_eq("rst_exec_run", 32'(inst_out), 32'h0567);
      check_eq("rst_exec_norest", 32'(ret_restore), 32'd0);

      // Random streams against the model
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rand_inst(), 3'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
